// File: rtl/dock_io_pkg.sv
`default_nettype none
// ============================================================================
// dock_io_pkg : shared types and constants for the Dock I/O cycle controller
// Rev 1.0
// ============================================================================
package dock_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } io_state_t;

    localparam logic [7:0] OP_ANY   = 8'hFF;
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h00;

    localparam int SLOT_W = 3;

endpackage
`default_nettype wire

// File: rtl/iorq_sync.sv
`default_nettype none
// ============================================================================
// iorq_sync : reset-to-0 /IORQ synchronizer with falling-edge detect
// Rev 1.0
// ============================================================================
module iorq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic iorq_n_i,
    output logic iorq_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a /IORQ held low through reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iorq_n_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign iorq_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o   = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/io_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// io_cycle_ctrl : sequences one Dock I/O cycle per /IORQ assertion
// Rev 1.0
// ============================================================================
module io_cycle_ctrl
    import dock_io_pkg::*;
#(
    parameter int NUM_SLOTS   = 5,
    parameter int WIN_INDEX_W = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iorq_n,
    input  logic                   win_valid,
    input  logic [WIN_INDEX_W-1:0] win_index,
    input  logic [SLOT_W-1:0]      sel_slot,
    input  logic                   is_read,
    input  logic [NUM_SLOTS-1:0]   slot_ready_n,
    output logic [NUM_SLOTS-1:0]   slot_cs_n,
    output logic                   io_rd_n,
    output logic                   io_wr_n,
    output logic                   cpu_wait,
    output logic [WIN_INDEX_W-1:0] cur_win,
    output logic                   busy,
    output logic                   cycle_done,
    output logic                   unclaimed,
    output logic                   bus_err,
    output logic                   abort
);

    localparam int SU_W    = (SETUP_CYC > 1)   ? $clog2(SETUP_CYC)   : 1;
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SLOT_CW = SLOT_W + 1;

    localparam logic [SU_W-1:0]    SU_LOAD  = SU_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [SLOT_CW-1:0] NS_LIMIT = SLOT_CW'(NUM_SLOTS);

    logic iorq_s;
    logic start;

    iorq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .iorq_n_i (iorq_n),
        .iorq_s_o (iorq_s),
        .fall_o   (start)
    );

    io_state_t              state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic                   rd_q, rd_d;
    logic                   done_ok_q, done_ok_d;
    logic [SU_W-1:0]        su_cnt_q, su_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [NUM_SLOTS-1:0]   cs_n_q, cs_n_d;
    logic                   rd_n_q, rd_n_d;
    logic                   wr_n_q, wr_n_d;
    logic                   wait_q, wait_d;
    logic [WIN_INDEX_W-1:0] win_q, win_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   unc_q, unc_d;
    logic                   berr_q, berr_d;
    logic                   abort_q, abort_d;

    logic                   claim;
    logic                   go_active;
    logic                   release_all;
    logic [SLOT_W-1:0]      act_slot;
    logic                   act_rd;

    assign claim = win_valid && ({1'b0, sel_slot} < NS_LIMIT);

    // With zero setup the strobes come straight from the live decode inputs.
    assign act_slot = (state_q == ST_IDLE) ? sel_slot : slot_q;
    assign act_rd   = (state_q == ST_IDLE) ? is_read  : rd_q;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        rd_d        = rd_q;
        done_ok_d   = done_ok_q;
        su_cnt_d    = su_cnt_q;
        to_cnt_d    = to_cnt_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        wait_d      = wait_q;
        win_d       = win_q;
        done_d      = 1'b0;
        unc_d       = 1'b0;
        berr_d      = 1'b0;
        abort_d     = 1'b0;
        go_active   = 1'b0;
        release_all = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_ok_d = 1'b0;
                    if (claim) begin
                        slot_d = sel_slot;
                        rd_d   = is_read;
                        win_d  = win_index;
                        wait_d = 1'b1;
                        if (SETUP_CYC == 0) begin
                            go_active = 1'b1;
                        end else begin
                            state_d  = ST_SETUP;
                            su_cnt_d = SU_LOAD;
                        end
                    end else begin
                        unc_d   = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_SETUP: begin
                if (iorq_s) begin
                    release_all = 1'b1;
                    abort_d     = 1'b1;
                end else if (su_cnt_q == '0) begin
                    go_active = 1'b1;
                end else begin
                    su_cnt_d = su_cnt_q - SU_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (iorq_s) begin
                    release_all = 1'b1;
                    abort_d     = 1'b1;
                end else if (!slot_ready_n[slot_q]) begin
                    wait_d    = 1'b0;
                    done_ok_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if ((TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST)) begin
                    wait_d    = 1'b0;
                    berr_d    = 1'b1;
                    done_ok_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (TIMEOUT_CYC != 0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_HOLD: begin
                if (iorq_s) begin
                    release_all = 1'b1;
                    done_d      = done_ok_q;
                end
            end
            default: begin
                release_all = 1'b1;
            end
        endcase

        if (go_active) begin
            state_d  = ST_ACTIVE;
            to_cnt_d = '0;
            cs_n_d   = ~(NUM_SLOTS'(1) << act_slot);
            rd_n_d   = ~act_rd;
            wr_n_d   = act_rd;
        end

        if (release_all) begin
            state_d = ST_IDLE;
            cs_n_d  = '1;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            wait_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            rd_q      <= 1'b0;
            done_ok_q <= 1'b0;
            su_cnt_q  <= '0;
            to_cnt_q  <= '0;
            cs_n_q    <= '1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            wait_q    <= 1'b0;
            win_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            unc_q     <= 1'b0;
            berr_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rd_q      <= rd_d;
            done_ok_q <= done_ok_d;
            su_cnt_q  <= su_cnt_d;
            to_cnt_q  <= to_cnt_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            wait_q    <= wait_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            unc_q     <= unc_d;
            berr_q    <= berr_d;
            abort_q   <= abort_d;
        end
    end

    assign slot_cs_n  = cs_n_q;
    assign io_rd_n    = rd_n_q;
    assign io_wr_n    = wr_n_q;
    assign cpu_wait   = wait_q;
    assign cur_win    = win_q;
    assign busy       = busy_q;
    assign cycle_done = done_q;
    assign unclaimed  = unc_q;
    assign bus_err    = berr_q;
    assign abort      = abort_q;

endmodule
`default_nettype wire
